// File: rtl/adc_pair_sampler_pkg.sv
// Shared types for the igniter V/I pair sampler.
//   ADC_W / CHAN_W : ADC result width and channel-number width
//   adc_sample_t   : raw ADC code, never reformatted along this path
//   adc_chan_t     : ADC channel number
//   pair_state_t   : pairing FSM states
//   sat_inc8       : saturating 8-bit increment used by the drop counter
package adc_pair_pkg;

  localparam int ADC_W  = 12;
  localparam int CHAN_W = 5;

  typedef logic [ADC_W-1:0]  adc_sample_t;
  typedef logic [CHAN_W-1:0] adc_chan_t;

  typedef enum logic [1:0] {
    S_EMPTY,
    S_HAVE_V,
    S_HAVE_I,
    S_READY
  } pair_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/adc_pair_sampler_if.sv
// Bus bundle between the ADC stream / control side and the pair sampler.
//   enable                        : sampling enable (low flushes the pair)
//   adc_valid, adc_chan, adc_data : ADC conversion stream
//   valid_out, v_out, i_out       : paired sample towards the resistance divider
//   drop_cnt, pair_err            : status
// master = the environment driving the ADC stream, slave = the sampler.
interface adc_pair_sampler_if;
  import adc_pair_pkg::*;

  logic        enable;
  logic        adc_valid;
  adc_chan_t   adc_chan;
  adc_sample_t adc_data;
  logic        valid_out;
  adc_sample_t v_out;
  adc_sample_t i_out;
  logic [7:0]  drop_cnt;
  logic        pair_err;

  modport master (
    output enable, adc_valid, adc_chan, adc_data,
    input  valid_out, v_out, i_out, drop_cnt, pair_err
  );

  modport slave (
    input  enable, adc_valid, adc_chan, adc_data,
    output valid_out, v_out, i_out, drop_cnt, pair_err
  );

endinterface

// File: rtl/adc_pair_sampler_gap_timer.sv
// pair_gap_timer: saturating down-counter.
//   clk, reset : clock, asynchronous active-high reset
//   load       : reload the counter with COUNT-1
//   done       : counter has reached zero (also true straight after reset)
// Loading on an event in cycle p makes done rise exactly COUNT edges later,
// so a decision taken on done can first take effect in cycle p+COUNT.
module pair_gap_timer #(
  parameter int COUNT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic done
);

  localparam int W = (COUNT > 1) ? $clog2(COUNT) : 1;

  logic [W-1:0] cnt_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= W'(COUNT - 1);
    end else if (cnt_reg != '0) begin
      cnt_reg <= cnt_reg - W'(1);
    end
  end

  assign done = (cnt_reg == '0);

endmodule

// File: rtl/adc_pair_sampler.sv
// adc_pair_sampler: captures one igniter-voltage and one igniter-current ADC
// sample, pairs them and issues the pair as a one-cycle valid_out pulse,
// never closer than MIN_GAP cycles to the previous pulse.
//   clk   : system clock
//   reset : asynchronous active-high reset
//   bus   : adc_pair_sampler_if.slave (enable, ADC stream in; pair + status out)
// Optional feature macro: ADC_PAIR_TIMEOUT_EN -- a partial pair older than
// TIMEOUT cycles is discarded and the sticky pair_err flag sets. Without the
// macro, partial pairs wait indefinitely and pair_err is tied low.
module adc_pair_sampler
  import adc_pair_pkg::*;
#(
  parameter adc_chan_t V_CHAN  = 5'd1,
  parameter adc_chan_t I_CHAN  = 5'd2,
  parameter int        MIN_GAP = 16,
  parameter int        TIMEOUT = 1023
) (
  input logic             clk,
  input logic             reset,
  adc_pair_sampler_if.slave bus
);

  // Illegal parameter sets elaborate nothing extra; this only keeps every
  // parameter referenced in every build.
  if ((V_CHAN == I_CHAN) || (MIN_GAP < 1) || (TIMEOUT < 1)) begin : g_illegal_params
  end

  pair_state_t state_reg, state_next;
  logic        sample_v, sample_i;
  logic        issue, drop, gap_ok, timeout_hit;
  logic [1:0]  hit, take;
  adc_sample_t hold_reg [2];
  adc_sample_t issue_v, issue_i;

  logic        valid_out_reg;
  adc_sample_t v_out_reg, i_out_reg;
  logic [7:0]  drop_cnt_reg;

  assign sample_v = bus.adc_valid && (bus.adc_chan == V_CHAN);
  assign sample_i = bus.adc_valid && (bus.adc_chan == I_CHAN);
  assign hit      = {sample_i, sample_v};

  // Reloaded on every issue; done means the divider can accept a new pair.
  pair_gap_timer #(.COUNT(MIN_GAP)) u_gap_timer (
    .clk   (clk),
    .reset (reset),
    .load  (issue),
    .done  (gap_ok)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  // When the partner arrives and the gap is already satisfied the pair is
  // issued on that same edge straight from the incoming data, giving the
  // one-cycle latency; S_READY is only used to wait out the gap.
  always_comb begin
    state_next = state_reg;
    issue      = 1'b0;
    drop       = 1'b0;
    issue_v    = hold_reg[0];
    issue_i    = hold_reg[1];
    if (!bus.enable) begin
      state_next = S_EMPTY;
    end else begin
      case (state_reg)
        S_EMPTY: begin
          if (sample_v) begin
            state_next = S_HAVE_V;
          end else if (sample_i) begin
            state_next = S_HAVE_I;
          end
        end
        S_HAVE_V: begin
          if (sample_i) begin
            issue_i = bus.adc_data;
            if (gap_ok) begin
              issue      = 1'b1;
              state_next = S_EMPTY;
            end else begin
              state_next = S_READY;
            end
          end else if (timeout_hit) begin
            state_next = S_EMPTY;
          end
        end
        S_HAVE_I: begin
          if (sample_v) begin
            issue_v = bus.adc_data;
            if (gap_ok) begin
              issue      = 1'b1;
              state_next = S_EMPTY;
            end else begin
              state_next = S_READY;
            end
          end else if (timeout_hit) begin
            state_next = S_EMPTY;
          end
        end
        S_READY: begin
          drop = sample_v || sample_i;
          if (gap_ok) begin
            issue      = 1'b1;
            state_next = S_EMPTY;
          end
        end
        default: state_next = S_EMPTY;
      endcase
    end
  end

  // Hold registers: index 0 = voltage, 1 = current. Writing whenever a
  // matching sample arrives outside S_READY gives newest-wins overwrites;
  // a write after a timeout is harmless because the FSM is then empty.
  for (genvar gi = 0; gi < 2; gi++) begin : g_hold
    assign take[gi] = bus.enable && hit[gi] && (state_reg != S_READY);

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        hold_reg[gi] <= '0;
      end else if (take[gi]) begin
        hold_reg[gi] <= bus.adc_data;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_out_reg <= 1'b0;
      v_out_reg     <= '0;
      i_out_reg     <= '0;
      drop_cnt_reg  <= '0;
    end else begin
      valid_out_reg <= issue;
      if (issue) begin
        v_out_reg <= issue_v;
        i_out_reg <= issue_i;
      end
      if (drop) begin
        drop_cnt_reg <= sat_inc8(drop_cnt_reg);
      end
    end
  end

  assign bus.valid_out = valid_out_reg;
  assign bus.v_out     = v_out_reg;
  assign bus.i_out     = i_out_reg;
  assign bus.drop_cnt  = drop_cnt_reg;

`ifdef ADC_PAIR_TIMEOUT_EN
  logic to_load, to_fire, pair_err_reg;

  // Started only on entry from S_EMPTY, so overwrites do not extend the wait.
  assign to_load = bus.enable && (state_reg == S_EMPTY) && (sample_v || sample_i);

  pair_gap_timer #(.COUNT(TIMEOUT)) u_timeout_timer (
    .clk   (clk),
    .reset (reset),
    .load  (to_load),
    .done  (timeout_hit)
  );

  // A partner arriving on the expiry edge still completes the pair.
  assign to_fire = bus.enable && timeout_hit &&
                   (((state_reg == S_HAVE_V) && !sample_i) ||
                    ((state_reg == S_HAVE_I) && !sample_v));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pair_err_reg <= 1'b0;
    end else if (to_fire) begin
      pair_err_reg <= 1'b1;
    end
  end

  assign bus.pair_err = pair_err_reg;
`else
  assign timeout_hit  = 1'b0;
  assign bus.pair_err = 1'b0;
`endif

endmodule
